bp_event_counter_sampler: RTL and testbench

BP_EVENT_COUNTER_SAMPLER -- requirements
Module: bp_event_counter_sampler

---
 rtl/bp_event_counter_pkg.sv | 9 +
 rtl/bsg_counter_clear_up.sv | 24 ++
 rtl/bp_event_counter_sampler.sv | 113 +++++++++++
 tb/tb_bp_event_counter_sampler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_event_counter_pkg.sv
// Shared types for the event counter sampler.
package bp_event_counter_pkg;

    typedef enum logic {
        e_sampler_idle   = 1'b0,
        e_sampler_stream = 1'b1
    } sampler_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together load 1.
module bsg_counter_clear_up #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (clear_i && up_i) begin
            count_o <= {{(width_p-1){1'b0}}, 1'b1};
        end else if (clear_i) begin
            count_o <= '0;
        end else if (up_i) begin
            count_o <= count_o + 1'b1;
        end
    end

endmodule

// File: rtl/bp_event_counter_sampler.sv
// Snapshots a bank of live event counters on a periodic or host trigger and
// streams them out as a header word followed by one word per counter.
module bp_event_counter_sampler
    import bp_event_counter_pkg::*;
#(
    parameter int width_p          = 32,
    parameter int num_counters_p   = 22,
    parameter int interval_width_p = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              freeze_i,
    input  logic                              enable_i,
    input  logic [interval_width_p-1:0]       interval_i,
    input  logic                              sample_req_i,
    input  logic [num_counters_p*width_p-1:0] counters_i,
    output logic [width_p-1:0]                data_o,
    output logic                              v_o,
    input  logic                              ready_and_i,
    output logic                              last_o,
    output logic                              busy_o,
    output logic [width_p-1:0]                dropped_o
);

    localparam int idx_width_lp = $clog2(num_counters_p + 1);
    localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(num_counters_p);

    sampler_state_e state, state_n;
    logic [idx_width_lp-1:0]           idx;
    logic [interval_width_p-1:0]       tick;
    logic [width_p-1:0]                seq;
    logic [width_p-1:0]                header;
    logic [num_counters_p*width_p-1:0] snap;

    logic tick_run, periodic_trig, trigger;
    logic busy, accept, is_last, capture, saturated;

    assign tick_run      = enable_i & ~freeze_i & (interval_i != '0);
    assign periodic_trig = tick_run & (tick == interval_i - 1'b1);
    assign trigger       = (periodic_trig | sample_req_i) & ~freeze_i;

    assign busy      = (state == e_sampler_stream);
    assign accept    = busy & ready_and_i;
    assign is_last   = busy & (idx == last_idx_lp);
    assign capture   = (state == e_sampler_idle) & trigger;
    assign saturated = &dropped_o;

    always_ff @(posedge clk_i) begin
        if (reset_i || !tick_run) begin
            tick <= '0;
        end else if (periodic_trig) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= e_sampler_idle;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            e_sampler_idle:   if (trigger) state_n = e_sampler_stream;
            e_sampler_stream: if (accept && is_last) state_n = e_sampler_idle;
            default:          state_n = e_sampler_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idx <= '0;
            seq <= '0;
        end else if (capture) begin
            idx <= '0;
            seq <= seq + 1'b1;
        end else if (accept) begin
            idx <= is_last ? '0 : idx + 1'b1;
        end
    end

    // The snapshot is a shift register: counter words drain from the low end
    // as they are accepted, so the current word is always at bit 0.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            snap   <= counters_i;
            header <= seq;
        end else if (accept && idx != '0) begin
            snap <= snap >> width_p;
        end
    end

    bsg_counter_clear_up #(
        .width_p(width_p)
    ) dropped_counter (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(1'b0),
        .up_i   (trigger & busy & ~saturated),
        .count_o(dropped_o)
    );

    assign data_o = (idx == '0) ? header : snap[width_p-1:0];
    assign v_o    = busy;
    assign busy_o = busy;
    assign last_o = is_last;

endmodule

// File: tb/tb_bp_event_counter_sampler.sv
// Directed and randomized checks of the event counter sampler against a
// queue-based reference model of the snapshot stream.
module tb_bp_event_counter_sampler;

    localparam int W  = 8;
    localparam int N  = 22;
    localparam int IW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, freeze, enable, sample_req, ready_and;
    logic [IW-1:0] interval;
    logic [N*W-1:0] counters;
    logic [W-1:0]  data, dropped;
    logic          v, last, busy;

    bp_event_counter_sampler #(
        .width_p(W),
        .num_counters_p(N),
        .interval_width_p(IW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .freeze_i    (freeze),
        .enable_i    (enable),
        .interval_i  (interval),
        .sample_req_i(sample_req),
        .counters_i  (counters),
        .data_o      (data),
        .v_o         (v),
        .ready_and_i (ready_and),
        .last_o      (last),
        .busy_o      (busy),
        .dropped_o   (dropped)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a stream is a queue of words still to be delivered.
    bit           m_busy = 1'b0;
    logic [W-1:0] m_words[$];
    int           m_seq   = 0;
    int           m_drop  = 0;
    int           m_phase = 0;
    int           acc_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit fire, trig;
        if (reset) begin
            m_busy  = 1'b0;
            m_words.delete();
            m_seq   = 0;
            m_drop  = 0;
            m_phase = 0;
        end else begin
            fire = enable && !freeze && interval != 0 && m_phase == int'(interval) - 1;
            if (!enable || freeze || interval == 0) m_phase = 0;
            else m_phase = fire ? 0 : m_phase + 1;
            trig = (fire || sample_req) && !freeze;
            if (m_busy) begin
                if (trig && m_drop < (1 << W) - 1) m_drop++;
                if (ready_and) begin
                    void'(m_words.pop_front());
                    if (m_words.size() == 0) m_busy = 1'b0;
                end
            end else if (trig) begin
                m_words.push_back(W'(m_seq));
                for (int k = 0; k < N; k++) m_words.push_back(counters[k*W +: W]);
                m_seq  = (m_seq + 1) % (1 << W);
                m_busy = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic [W-1:0] md;
        md = m_drop[W-1:0];
        chk("v_o", v, m_busy);
        chk("busy_o", busy, m_busy);
        chk("dropped_o", dropped, md);
        chk("last_o", last, m_busy && m_words.size() == 1);
        if (m_busy) chk("data_o", data, m_words[0]);
        if (v && ready_and) acc_cnt++;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_counters();
        for (int k = 0; k < N; k++) counters[k*W +: W] = W'($urandom);
    endtask

    initial begin
        int d0;
        logic [W-1:0] held;
        bit stalled;

        reset = 1'b1; freeze = 1'b0; enable = 1'b0; sample_req = 1'b0;
        ready_and = 1'b0; interval = '0;
        for (int k = 0; k < N; k++) counters[k*W +: W] = W'(k + 100);
        @(negedge clk);
        repeat (2) step();
        reset = 1'b0;

        // Single host request, always-ready consumer.
        ready_and = 1'b1;
        acc_cnt = 0;
        sample_req = 1'b1; step(); sample_req = 1'b0;
        repeat (30) step();
        chk("t1_word_count", acc_cnt, 23);
        chk("t1_idle", busy, 1'b0);

        // Periodic sampling, then interval 0 disables it.
        enable = 1'b1; interval = 16'd10;
        repeat (70) begin rand_counters(); step(); end
        interval = '0;
        repeat (40) step();
        chk("no_periodic", busy, 1'b0);
        enable = 1'b0;

        // Random backpressure; held word must not move while stalled.
        sample_req = 1'b1; rand_counters(); step(); sample_req = 1'b0;
        repeat (80) begin
            ready_and = 1'($urandom_range(0, 1));
            rand_counters();
            stalled = v && !ready_and;
            held = data;
            step();
            if (stalled) chk("stall_hold", data, held);
        end
        ready_and = 1'b1;
        repeat (30) step();

        // Three requests while busy are dropped, then saturation.
        d0 = m_drop;
        sample_req = 1'b1; step(); sample_req = 1'b0;
        ready_and = 1'b0;
        repeat (3) begin step(); sample_req = 1'b1; step(); sample_req = 1'b0; end
        chk("drop3", dropped, 32'(d0 + 3));
        ready_and = 1'b1;
        repeat (30) step();
        sample_req = 1'b1; step();
        ready_and = 1'b0;
        repeat (300) step();
        sample_req = 1'b0;
        chk("drop_sat", dropped, 8'hff);
        ready_and = 1'b1;
        repeat (30) step();

        // Freeze mid-stream: stream completes, later requests are ignored.
        sample_req = 1'b1; step(); sample_req = 1'b0;
        repeat (5) step();
        freeze = 1'b1;
        repeat (30) step();
        chk("frz_done", busy, 1'b0);
        d0 = m_drop;
        sample_req = 1'b1; repeat (3) step(); sample_req = 1'b0;
        step();
        chk("frz_drop", dropped, 32'(d0));
        chk("frz_idle", v, 1'b0);
        freeze = 1'b0;

        // Reset while word 5 is on the bus.
        sample_req = 1'b1; step(); sample_req = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 50 && acc_cnt < 5; i++) step();
        chk("word5_reached", acc_cnt, 5);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_v", v, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dropped", dropped, '0);
        sample_req = 1'b1; step(); sample_req = 1'b0;
        chk("rst_hdr_v", v, 1'b1);
        chk("rst_hdr", data, '0);
        repeat (30) step();

        // Randomized mix of all controls.
        enable = 1'b1;
        interval = IW'($urandom_range(3, 30));
        repeat (400) begin
            sample_req = ($urandom_range(0, 19) == 0);
            ready_and  = ($urandom_range(0, 3) != 0);
            freeze     = ($urandom_range(0, 15) == 0);
            rand_counters();
            step();
        end
        sample_req = 1'b0; ready_and = 1'b1; freeze = 1'b0; enable = 1'b0;
        repeat (40) step();
        chk("final_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
